// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle control sequencer for the 8-bit accumulator CPU
//
// Steps the pc/ir/acc/zf datapath through FETCH, DECODE, EXEC and optional MEM/WB
// states. It decodes the IR opcode and zero flag, handshakes with memory, and flags
// memory timeouts (sticky bus_err) and undefined opcodes (illegal_op pulse).
//
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   ir_opcode[3:0]     ir[7:4], meaningful from the cycle after ir_load
//   zf                 accumulator zero flag, sampled by JZ in EXEC
//   mem_ready          memory completes the pending mem_rd/mem_wr this cycle
//   mem_rd, mem_wr     memory requests, held until mem_ready or timeout
//   addr_sel           0 = address from pc, 1 = address from ir[3:0]
//   ir_load            capture read data into ir
//   pc_inc, pc_load    pc + 1 / pc <= {4'h0, ir[3:0]}
//   acc_load, alu_op   acc <= ALU result (zf updates); ALU function select
//   out_load           out_port <= acc
//   halted, bus_err    HALT state / sticky memory timeout flag
//   illegal_op         one-cycle pulse in EXEC for opcodes C, D, E

module cpu_ctrl_seq #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ir_opcode,
  input  logic       zf,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [2:0] alu_op,
  output logic       out_load,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // The timeout fires on the WAIT_LIMIT-th stalled cycle, so compare against limit-1.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       is_store;
  logic       is_read;

  assign is_store = (ir_opcode == 4'h2);
  assign is_read  = (ir_opcode inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7});
  assign bus_err  = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = 8'd0;  // cleared whenever we are not stalling, so every FETCH/MEM entry starts at 0
    bus_err_d  = bus_err_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    alu_op     = 3'd0;
    out_load   = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_rd = 1'b1;
        // A ready in the limit cycle still completes the fetch.
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        pc_inc  = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_opcode)
          4'h0: ;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = S_MEM;
          4'h8: pc_load = 1'b1;
          4'h9: pc_load = zf;
          4'hA: out_load = 1'b1;
          4'hB: begin
            acc_load = 1'b1;
            alu_op   = 3'd6;
          end
          4'hF: state_d = S_HALT;
          default: illegal_op = 1'b1;
        endcase
      end

      S_MEM: begin
        addr_sel = 1'b1;
        mem_wr   = is_store;
        mem_rd   = is_read;
        if (mem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        acc_load = 1'b1;
        // LDA passes memory; ADD..XOR (opcodes 3..7) map onto ALU ops 1..5.
        alu_op   = (ir_opcode == 4'h1) ? 3'd0 : 3'(ir_opcode[2:0] - 3'd2);
        state_d  = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - scoreboard testbench for cpu_ctrl_seq

module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic       zf = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load;
  logic [2:0] alu_op;
  logic       out_load, halted, bus_err, illegal_op;

  cpu_ctrl_seq #(.WAIT_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_opcode (ir_opcode),
    .zf        (zf),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr_sel  (addr_sel),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .out_load  (out_load),
    .halted    (halted),
    .bus_err   (bus_err),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [13:0] got;
  assign got = {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load,
                alu_op, out_load, halted, bus_err, illegal_op};

  localparam logic [13:0] V_RD   = 14'h2000;
  localparam logic [13:0] V_WR   = 14'h1000;
  localparam logic [13:0] V_AS   = 14'h0800;
  localparam logic [13:0] V_IRL  = 14'h0400;
  localparam logic [13:0] V_PCI  = 14'h0200;
  localparam logic [13:0] V_PCL  = 14'h0100;
  localparam logic [13:0] V_ACC  = 14'h0080;
  localparam logic [13:0] V_OUT  = 14'h0008;
  localparam logic [13:0] V_HLT  = 14'h0004;
  localparam logic [13:0] V_BERR = 14'h0002;
  localparam logic [13:0] V_ILL  = 14'h0001;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  op;
    logic        z;
    logic [13:0] exp;
  } step_t;

  step_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [13:0] alu_f(input int n);
    return 14'(n) << 4;
  endfunction

  function automatic logic [13:0] exec_vec(input logic [3:0] op, input logic z);
    case (op)
      4'h8:             return V_PCL;
      4'h9:             return z ? V_PCL : 14'h0;
      4'hA:             return V_OUT;
      4'hB:             return V_ACC | alu_f(6);
      4'hC, 4'hD, 4'hE: return V_ILL;
      default:          return 14'h0;
    endcase
  endfunction

  function automatic int wb_alu(input logic [3:0] op);
    case (op)
      4'h1: return 0;
      4'h3: return 1;
      4'h4: return 2;
      4'h5: return 3;
      4'h6: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic push(input logic rdy, input logic [3:0] op, input logic z, input logic [13:0] exp);
    sb.push_back('{rdy: rdy, op: op, z: z, exp: exp});
  endtask

  // Queues one full instruction: fw stalled fetch cycles, mw stalled MEM cycles.
  task automatic push_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    logic        rd_op;
    logic [13:0] mem_v;
    rd_op = (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7});
    for (int i = 0; i < fw; i++) push(1'b0, op, z, V_RD);
    push(1'b1, op, z, V_RD | V_IRL);
    push(1'b0, op, z, V_PCI);
    push(1'b0, op, z, exec_vec(op, z));
    if (rd_op || op == 4'h2) begin
      mem_v = V_AS | ((op == 4'h2) ? V_WR : V_RD);
      for (int i = 0; i < mw; i++) push(1'b0, op, z, mem_v);
      push(1'b1, op, z, mem_v);
      if (rd_op) push(1'b0, op, z, V_ACC | alu_f(wb_alu(op)));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step_t s;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (got !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%h expected=%h", got, 14'h0);
    end
    rst_n = 1'b1;
    push(1'b0, 4'h0, 1'b0, 14'h0);
    push_instr(4'h0, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL reset_release op=%h: outputs=%h expected=%h", s.op, got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ldi_out_hlt();
    step_t s;
    push_instr(4'hB, 1'b0, 0, 0);
    push_instr(4'hA, 1'b0, 0, 0);
    push_instr(4'hF, 1'b0, 0, 0);
    push(1'b0, 4'hF, 1'b0, V_HLT);
    push(1'b1, 4'hF, 1'b0, V_HLT);
    push(1'b1, 4'h0, 1'b1, V_HLT);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL ldi_out_hlt op=%h: outputs=%h expected=%h", s.op, got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jumps();
    step_t s;
    do_reset();
    push(1'b0, 4'h0, 1'b0, 14'h0);
    push_instr(4'h8, 1'b0, 0, 0);
    push_instr(4'h9, 1'b1, 0, 0);
    push_instr(4'h9, 1'b0, 0, 0);
    push_instr(4'h0, 1'b1, 1, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL jumps op=%h zf=%b: outputs=%h expected=%h", s.op, s.z, got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_ops();
    step_t s;
    push_instr(4'h3, 1'b0, 0, 3);
    push_instr(4'h1, 1'b0, 2, 0);
    push_instr(4'h4, 1'b0, 0, 0);
    push_instr(4'h5, 1'b0, 0, 1);
    push_instr(4'h6, 1'b0, 0, 0);
    push_instr(4'h7, 1'b1, 0, 2);
    push_instr(4'h2, 1'b0, 0, 0);
    push_instr(4'h2, 1'b0, 0, 2);
    push_instr(4'hC, 1'b0, 0, 0);
    push_instr(4'hD, 1'b0, 0, 0);
    push_instr(4'hE, 1'b0, 0, 0);
    push_instr(4'h1, 1'b0, 7, 7);  // ready arrives on the limit cycle: no error
    push_instr(4'h2, 1'b0, 0, 7);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL mem_ops op=%h: outputs=%h expected=%h", s.op, got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    do_reset();
    push(1'b0, 4'h1, 1'b0, 14'h0);
    push(1'b1, 4'h1, 1'b0, V_RD | V_IRL);
    push(1'b0, 4'h1, 1'b0, V_PCI);
    push(1'b0, 4'h1, 1'b0, 14'h0);
    for (int i = 0; i < 8; i++) push(1'b0, 4'h1, 1'b0, V_RD | V_AS);
    for (int i = 0; i < 3; i++) push(1'(i % 2), 4'h1, 1'b0, V_HLT | V_BERR);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL mem_timeout: outputs=%h expected=%h", got, s.exp);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    push(1'b0, 4'h0, 1'b0, 14'h0);
    for (int i = 0; i < 8; i++) push(1'b0, 4'h0, 1'b0, V_RD);
    push(1'b1, 4'h0, 1'b0, V_HLT | V_BERR);
    push(1'b1, 4'h0, 1'b0, V_HLT | V_BERR);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL fetch_timeout: outputs=%h expected=%h", got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t s;
    do_reset();
    push(1'b0, 4'h3, 1'b0, 14'h0);
    push(1'b1, 4'h3, 1'b0, V_RD | V_IRL);
    push(1'b0, 4'h3, 1'b0, V_PCI);
    push(1'b0, 4'h3, 1'b0, 14'h0);
    push(1'b0, 4'h3, 1'b0, V_RD | V_AS);
    push(1'b0, 4'h3, 1'b0, V_RD | V_AS);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL pre_reset_mem: outputs=%h expected=%h", got, s.exp);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (got !== 14'h0) begin
      miscompares++;
      $display("FAIL async_reset_mem: outputs=%h expected=%h", got, 14'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(1'b0, 4'h0, 1'b0, 14'h0);
    push_instr(4'h0, 1'b0, 0, 0);
    push_instr(4'h1, 1'b0, 7, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; ir_opcode = s.op; zf = s.z;
      @(negedge clk);
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL post_reset op=%h: outputs=%h expected=%h", s.op, got, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_ldi_out_hlt();
    test_jumps();
    test_mem_ops();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
